// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler between the CPU load port, a direct-mapped cache and word-serial memory.
// A request is looked up in the cache. On a hit the CPU gets cpu_ready three cycles after the
// request edge. On a miss the 16-word block is fetched one word per mem_req/mem_ack handshake,
// written into the cache in a single fill cycle (cache_read=0), and then cpu_ready is pulsed.
// Ports: clk, rst_n (sync, active low); CPU side cpu_req/cpu_addr -> cpu_ready/busy;
//   cache side cache_addr/cache_read/fill_data <- cache_hit; memory side mem_req/mem_addr <- mem_ack/mem_rdata.
// Config: define CRITICAL_WORD_FIRST_EN to start the refill at the requested word offset and wrap;
//   otherwise the refill always runs from offset 0 to 15.
module cache_refill_ctrl #(
  parameter int WORD_W   = 32,
  parameter int WORDS    = 16,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic                    busy,
  output logic [ADDR_W-1:0]       cache_addr,
  output logic                    cache_read,
  input  logic                    cache_hit,
  output logic [WORDS*WORD_W-1:0] fill_data,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [WORD_W-1:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, REFILL, FILL, RESP} state_t;
  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(WORDS - 1);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [OFFSET_W-1:0] r_beat, r_cnt, w_start;
  logic [WORDS*WORD_W-1:0] r_fill;
`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start = r_addr[OFFSET_W-1:0];
`else
  assign w_start = '0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next     = r_state;
    cpu_ready  = r_state == RESP;
    busy       = r_state != IDLE;
    cache_read = r_state != FILL;
    mem_req    = r_state == REFILL;
    cache_addr = r_addr;
    mem_addr   = {r_addr[ADDR_W-1:OFFSET_W], r_beat};
    fill_data  = r_fill;
    case (r_state)
      IDLE:    w_next = cpu_req ? LOOKUP : IDLE;
      LOOKUP:  w_next = CHECK;
      CHECK:   w_next = cache_hit ? RESP : REFILL;
      REFILL:  w_next = (mem_ack && r_cnt == LAST) ? FILL : REFILL;
      FILL:    w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // r_cnt counts accepted beats independently of r_beat, which may start mid-block and wrap.
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_addr <= '0;
      r_beat <= '0;
      r_cnt  <= '0;
      r_fill <= '0;
    end else begin
      if (r_state == IDLE && cpu_req) r_addr <= cpu_addr;
      if (r_state == CHECK && !cache_hit) begin
        r_beat <= w_start;
        r_cnt  <= '0;
      end
      if (r_state == REFILL && mem_ack) begin
        r_fill[r_beat*WORD_W +: WORD_W] <= mem_rdata;
        r_beat <= r_beat + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: vector table, hand sequences and random requests against a transaction-level model.
module tb_cache_refill_ctrl;
  logic clk = 0, rst_n = 0, cpu_req = 0, cache_hit = 0, mem_ack = 0;
  logic [31:0] cpu_addr = 0, mem_rdata = 0;
  logic cpu_ready, busy, cache_read, mem_req;
  logic [31:0] cache_addr, mem_addr;
  logic [511:0] fill_data;
  int errors = 0, checks = 0;
  logic [511:0] exp_line = '0;
  logic [31:0] first_maddr = 0;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    bit hit;
    int gap_max;
    bit spur;
    bit pat;
    int exp_lat;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  cache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .busy(busy), .cache_addr(cache_addr), .cache_read(cache_read), .cache_hit(cache_hit),
    .fill_data(fill_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit pat);
    return pat ? (32'hA000_0000 | {28'd0, a[3:0]}) : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction
  // Entered and left at a negedge with the DUT idle.
  task automatic run_req(input logic [31:0] addr, input bit hit, input int gap_max,
                         input bit spur, input bit pat, input int exp_lat);
    logic [3:0] start;
    int beats, gap, gaps, lat, nf;
    bit seen;
    start = CWF ? addr[3:0] : 4'd0;
    beats = 0; gaps = 0; lat = 0; nf = 0; seen = 0;
    gap = $urandom_range(0, gap_max);
    cpu_req = 1; cpu_addr = addr; cache_hit = hit; mem_ack = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      mem_ack = 0;
      if (cpu_ready) begin
        lat = c;
        cpu_req = 0;
        break;
      end
      cpu_req = spur;
      cpu_addr = spur ? $urandom : addr;
      if (!cache_read) begin
        nf++;
        chk("fill_after_all_beats", beats, 16);
        chk("fill_line", fill_data, exp_line);
      end
      if (mem_req) begin
        if (!seen) first_maddr = mem_addr;
        seen = 1;
        chk("beat_count_bound", beats < 16, 1);
        chk("mem_addr", mem_addr, {addr[31:4], 4'(start + beats)});
        if (gap > 0) begin
          gap--;
          gaps++;
        end else begin
          mem_ack = 1;
          mem_rdata = mem_word({addr[31:4], 4'(start + beats)}, pat);
          exp_line[32*(4'(start + beats)) +: 32] = mem_word({addr[31:4], 4'(start + beats)}, pat);
          beats++;
          gap = $urandom_range(0, gap_max);
        end
      end else if (spur) begin
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
    chk("latency", lat, exp_lat + gaps);
    chk("beats", beats, hit ? 0 : 16);
    chk("fill_cycles", nf, hit ? 0 : 1);
    chk("resp_cache_addr", cache_addr, addr);
    chk("resp_line", fill_data, exp_line);
    chk("resp_cache_read", cache_read, 1);
    mem_ack = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cpu_ready, 0);
  endtask
  initial begin
    int nf;
    vecs[0] = '{32'h0000_1234, 1'b1, 0, 1'b0, 1'b1, 3};
    vecs[1] = '{32'h0000_2345, 1'b0, 0, 1'b0, 1'b1, 20};
    vecs[2] = '{32'h0000_2345, 1'b0, 5, 1'b1, 1'b1, 20};
    vecs[3] = '{32'h0000_234D, 1'b0, 0, 1'b0, 1'b1, 20};
    vecs[4] = '{32'h0000_1234, 1'b1, 2, 1'b1, 1'b1, 3};
    vecs[5] = '{32'hFFFF_FFF0, 1'b0, 1, 1'b1, 1'b0, 20};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cache_read", cache_read, 1);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].addr, vecs[i].hit, vecs[i].gap_max, vecs[i].spur, vecs[i].pat, vecs[i].exp_lat);
      if (i == 1) chk("line_pattern", fill_data, {32'hA000_000F, 32'hA000_000E, 32'hA000_000D,
        32'hA000_000C, 32'hA000_000B, 32'hA000_000A, 32'hA000_0009, 32'hA000_0008, 32'hA000_0007,
        32'hA000_0006, 32'hA000_0005, 32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001,
        32'hA000_0000});
      if (i == 3) chk("first_beat", first_maddr, CWF ? 32'h0000_234D : 32'h0000_2340);
    end
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'h0000_5678; cache_hit = 0;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'h0000_9999;
    @(negedge clk);
    chk("abort_cache_addr", cache_addr, 32'h0000_5678);
    nf = 0;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      chk("abort_req", mem_req, 1);
      nf += cache_read ? 0 : 1;
      mem_ack = 1;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    chk("abort_still_refill", mem_req, 1);
    rst_n = 0; mem_ack = 1;
    @(negedge clk);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fill_data", fill_data, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_ready", cpu_ready, 0);
    @(negedge clk);
    rst_n = 1; cpu_req = 0; mem_ack = 0; exp_line = '0;
    repeat (3) begin
      @(negedge clk);
      nf += cache_read ? 0 : 1;
    end
    chk("abort_no_fill", nf, 0);
    chk("abort_idle", busy, 0);
    run_req(32'h0000_5678, 1'b0, 2, 1'b1, 1'b0, 20);
    for (int i = 0; i < 24; i++) begin
      bit h;
      h = 1'($urandom);
      run_req($urandom, h, $urandom_range(0, 3), 1'($urandom), 1'b0, h ? 3 : 20);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
